// File: rtl/cplx_pkg.sv
// Shared widths, saturation limits and sample type for the complex multiplier pipeline.
// Q3.13 signed samples by default.
package cplx_pkg;

    localparam int CPLX_IW = 3;
    localparam int CPLX_FW = 13;
    localparam int CPLX_W  = CPLX_IW + CPLX_FW;
    localparam int CPLX_W1 = CPLX_W + 1;

    localparam logic signed [CPLX_W-1:0] SAT_MAX = {1'b0, {(CPLX_W-1){1'b1}}};
    localparam logic signed [CPLX_W-1:0] SAT_MIN = {1'b1, {(CPLX_W-1){1'b0}}};

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fixed_point_multiplier.sv
// Combinational signed Qm.n multiplier; result truncated toward -inf, sign kept from the
// full product so term-level overflow wraps rather than saturating.
module fixed_point_multiplier #(
    parameter int INTEGER_WIDTH    = 3,
    parameter int FRACTIONAL_WIDTH = 13
) (
    input  logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] a,
    input  logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] b,
    output logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] p
);

    localparam int W = INTEGER_WIDTH + FRACTIONAL_WIDTH;

    logic signed [2*W-1:0] prod;
    logic                  unused_prod_bits;

    assign prod = a * b;
    assign p    = {prod[2*W-1], prod[INTEGER_WIDTH+2*FRACTIONAL_WIDTH-2 : FRACTIONAL_WIDTH]};

    // Guard bits above the kept field and the discarded fraction are dropped on purpose.
    assign unused_prod_bits = ^{prod[2*W-2 : INTEGER_WIDTH+2*FRACTIONAL_WIDTH-1],
                                prod[FRACTIONAL_WIDTH-1:0]};

endmodule

// File: rtl/sat_addsub.sv
// W-bit signed add/subtract with one guard bit, saturated back to W bits.
// sat flags that the clamp was applied.
module sat_addsub
    import cplx_pkg::*;
#(
    parameter int                W       = CPLX_W,
    parameter logic signed [W-1:0] MAX_VAL = SAT_MAX,
    parameter logic signed [W-1:0] MIN_VAL = SAT_MIN
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic                sub,
    output logic signed [W-1:0] result,
    output logic                sat
);

    logic signed [W:0] xe;
    logic signed [W:0] ye;
    logic signed [W:0] full;

    assign xe   = {x[W-1], x};
    assign ye   = {y[W-1], y};
    assign full = sub ? (xe - ye) : (xe + ye);

    always_comb begin
        result = full[W-1:0];
        sat    = 1'b0;
        if (full[W] != full[W-1]) begin
            sat    = 1'b1;
            result = full[W] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/complex_multiplier_pipe.sv
// Three-stage valid/ready complex multiplier: S1 operands, S2 four real products,
// S3 saturated (rr - ii) and (ri + ir). Combinational ready chain lets bubbles collapse.
module complex_multiplier_pipe
    import cplx_pkg::*;
#(
    parameter int INTEGER_WIDTH    = CPLX_IW,
    parameter int FRACTIONAL_WIDTH = CPLX_FW
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] in_ar,
    input  logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] in_ai,
    input  logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] in_br,
    input  logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] in_bi,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] out_re,
    output logic signed [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] out_im,
    output logic                                            out_sat
);

    localparam int W = INTEGER_WIDTH + FRACTIONAL_WIDTH;

    logic v1, v2, v3;
    logic en1, en2, en3;

    cplx_t s1_a, s1_b;
    logic signed [W-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    cplx_t s3_q;
    logic  s3_sat;

    logic signed [W-1:0] pp_rr, pp_ii, pp_ri, pp_ir;
    logic signed [W-1:0] re_d, im_d;
    logic                sat_re, sat_im;

    assign en3      = ~v3 | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;

    fixed_point_multiplier #(
        .INTEGER_WIDTH   (INTEGER_WIDTH),
        .FRACTIONAL_WIDTH(FRACTIONAL_WIDTH)
    ) u_mul_rr (
        .a(s1_a.re),
        .b(s1_b.re),
        .p(pp_rr)
    );

    fixed_point_multiplier #(
        .INTEGER_WIDTH   (INTEGER_WIDTH),
        .FRACTIONAL_WIDTH(FRACTIONAL_WIDTH)
    ) u_mul_ii (
        .a(s1_a.im),
        .b(s1_b.im),
        .p(pp_ii)
    );

    fixed_point_multiplier #(
        .INTEGER_WIDTH   (INTEGER_WIDTH),
        .FRACTIONAL_WIDTH(FRACTIONAL_WIDTH)
    ) u_mul_ri (
        .a(s1_a.re),
        .b(s1_b.im),
        .p(pp_ri)
    );

    fixed_point_multiplier #(
        .INTEGER_WIDTH   (INTEGER_WIDTH),
        .FRACTIONAL_WIDTH(FRACTIONAL_WIDTH)
    ) u_mul_ir (
        .a(s1_a.im),
        .b(s1_b.re),
        .p(pp_ir)
    );

    sat_addsub #(.W(W)) u_re (
        .x     (s2_rr),
        .y     (s2_ii),
        .sub   (1'b1),
        .result(re_d),
        .sat   (sat_re)
    );

    sat_addsub #(.W(W)) u_im (
        .x     (s2_ri),
        .y     (s2_ir),
        .sub   (1'b0),
        .result(im_d),
        .sat   (sat_im)
    );

    // Data registers load only with a valid sample so idle X inputs never reach the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s2_rr  <= '0;
            s2_ii  <= '0;
            s2_ri  <= '0;
            s2_ir  <= '0;
            s3_q   <= '0;
            s3_sat <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en1 && in_valid) begin
                s1_a <= '{re: in_ar, im: in_ai};
                s1_b <= '{re: in_br, im: in_bi};
            end

            if (en2) v2 <= v1;
            if (en2 && v1) begin
                s2_rr <= pp_rr;
                s2_ii <= pp_ii;
                s2_ri <= pp_ri;
                s2_ir <= pp_ir;
            end

            if (en3) v3 <= v2;
            if (en3 && v2) begin
                s3_q   <= '{re: re_d, im: im_d};
                s3_sat <= sat_re | sat_im;
            end
        end
    end

    assign out_valid = v3;
    assign out_re    = s3_q.re;
    assign out_im    = s3_q.im;
    assign out_sat   = s3_sat;

endmodule
